// File: rtl/eth_fcs_pkg.sv
// Shared CRC-32 constants, state type and small lane helpers for the Ethernet FCS inserter.
package eth_fcs_pkg;

   localparam logic [31:0] CRC32_POLY          = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT          = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT        = 32'hFFFFFFFF;
   localparam int          MIN_FRAME_BYTES_DEF = 60;

   typedef enum logic [1:0] {
      S_DATA = 2'd0,
      S_PAD  = 2'd1,
      S_FCS  = 2'd2
   } state_t;

   // Contiguous-from-LSB keep for n bytes, n in 0..8.
   function automatic logic [7:0] keep_mask(input logic [3:0] n);
      logic [7:0] m;
      m = 8'hFF >> (4'd8 - n);
      return m;
   endfunction

   function automatic logic [3:0] lead_ones(input logic [7:0] k);
      logic [3:0] n;
      logic       run;
      n   = '0;
      run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         run = run & k[i];
         if (run) n = n + 4'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/crc32_d64.sv
// Combinational reflected CRC-32 update over the first i_nbytes (1..8) lanes of a 64-bit word.
module crc32_d64
   import eth_fcs_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [63:0] i_data,
   input  logic [3:0]  i_nbytes,
   output logic [31:0] o_crc
);

   logic [31:0] w_c;

   always_comb begin
      w_c = i_crc;
      for (int b = 0; b < 8; b++) begin
         if (4'(b) < i_nbytes) begin
            w_c = w_c ^ {24'h0, i_data[8*b +: 8]};
            for (int k = 0; k < 8; k++)
               w_c = w_c[0] ? ((w_c >> 1) ^ CRC32_POLY) : (w_c >> 1);
         end
      end
      o_crc = w_c;
   end

endmodule

// File: rtl/eth_fcs_inserter.sv
// Appends the Ethernet FCS to 64-bit AXI-Stream frames through one registered output stage.
// Build option ETH_FCS_MIN_PAD_EN: zero-pad frames shorter than MIN_FRAME_BYTES before the FCS.
module eth_fcs_inserter
   import eth_fcs_pkg::*;
#(
   parameter int DATA_WIDTH      = 64,
   parameter int MIN_FRAME_BYTES = MIN_FRAME_BYTES_DEF
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [31:0]             frame_count,
   output logic                    err_tkeep
);

   state_t      r_state, w_state_nxt;
   logic [63:0] r_tdata;
   logic [7:0]  r_tkeep;
   logic        r_tlast, r_tvalid, r_err;
   logic [31:0] r_crc, r_fcs_hi, r_frame_count;
   logic [15:0] r_bcnt;
   logic [2:0]  r_fcs_n;

   logic        w_load, w_acc, w_ld, w_fin, w_err, w_olast;
   logic [3:0]  w_nb, w_n;
   logic [63:0] w_din, w_obeat;
   logic [7:0]  w_okeep;
   logic [31:0] w_crc_next, w_fcs;
   logic [95:0] w_ext;

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {13'h0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   function automatic logic [63:0] mask_bytes(input logic [63:0] d, input logic [3:0] n);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[8*i +: 8] = (4'(i) < n) ? d[8*i +: 8] : 8'h00;
      return m;
   endfunction

   assign w_load        = !r_tvalid || m_axis_tready;
   assign s_axis_tready = rstn && (r_state == S_DATA) && w_load;
   assign w_acc         = s_axis_tvalid && s_axis_tready;
   assign w_nb          = (lead_ones(s_axis_tkeep) == 4'd0) ? 4'd1 : lead_ones(s_axis_tkeep);
   assign w_err         = s_axis_tlast ? (s_axis_tkeep != keep_mask(w_nb)) : (s_axis_tkeep != 8'hFF);

   crc32_d64 u_crc (
      .i_crc    (r_crc),
      .i_data   (w_din),
      .i_nbytes (w_n),
      .o_crc    (w_crc_next)
   );

   // FCS bytes land right after the last payload byte; anything past lane 7 spills into w_ext[95:64].
   assign w_fcs = w_crc_next ^ CRC32_XOROUT;
   assign w_ext = {32'h0, w_din} | ({64'h0, w_fcs} << {w_n, 3'b000});

`ifdef ETH_FCS_MIN_PAD_EN
   logic [16:0] w_rem;
   assign w_rem = 17'(MIN_FRAME_BYTES) - {1'b0, r_bcnt};
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_ld        = 1'b0;
      w_fin       = 1'b0;
      w_n         = 4'd8;
      w_din       = s_axis_tdata;
      w_obeat     = '0;
      w_okeep     = '0;
      w_olast     = 1'b0;
      case (r_state)
         S_DATA: begin
            w_ld = w_acc;
            if (s_axis_tlast) begin
               w_n   = w_nb;
               w_fin = 1'b1;
               w_din = mask_bytes(s_axis_tdata, w_nb);
`ifdef ETH_FCS_MIN_PAD_EN
               if (({1'b0, r_bcnt} + {13'h0, w_nb}) < 17'(MIN_FRAME_BYTES)) begin
                  if (w_rem > 17'd8) begin
                     w_n   = 4'd8;
                     w_fin = 1'b0;
                  end else begin
                     w_n = w_rem[3:0];
                  end
               end
`endif
            end
         end
`ifdef ETH_FCS_MIN_PAD_EN
         S_PAD: begin
            w_ld  = w_load;
            w_din = '0;
            if (w_rem > 17'd8) begin
               w_n = 4'd8;
            end else begin
               w_n   = w_rem[3:0];
               w_fin = 1'b1;
            end
         end
`endif
         S_FCS: begin
            w_ld    = w_load;
            w_din   = '0;
            w_obeat = {32'h0, r_fcs_hi};
            w_okeep = keep_mask({1'b0, r_fcs_n});
            w_olast = 1'b1;
         end
         default: w_state_nxt = S_DATA;
      endcase

      if (r_state != S_FCS) begin
         if (w_fin) begin
            w_obeat = w_ext[63:0];
            w_okeep = (w_n >= 4'd4) ? 8'hFF : keep_mask(w_n + 4'd4);
            w_olast = (w_n <= 4'd4);
         end else begin
            w_obeat = w_din;
            w_okeep = 8'hFF;
            w_olast = 1'b0;
         end
      end

      if (w_ld) begin
         if (w_olast)
            w_state_nxt = S_DATA;
         else if (w_fin)
            w_state_nxt = S_FCS;
`ifdef ETH_FCS_MIN_PAD_EN
         else if (r_state == S_DATA && s_axis_tlast)
            w_state_nxt = S_PAD;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state       <= S_DATA;
         r_crc         <= CRC32_INIT;
         r_bcnt        <= '0;
         r_tvalid      <= 1'b0;
         r_tdata       <= '0;
         r_tkeep       <= '0;
         r_tlast       <= 1'b0;
         r_fcs_hi      <= '0;
         r_fcs_n       <= '0;
         r_frame_count <= '0;
         r_err         <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_tvalid <= w_ld;
            if (w_ld) begin
               r_tdata <= w_obeat;
               r_tkeep <= w_okeep;
               r_tlast <= w_olast;
            end
         end
         // CRC and byte count restart as soon as the FCS has been computed.
         if (w_ld) begin
            if (w_fin || w_olast) begin
               r_crc  <= CRC32_INIT;
               r_bcnt <= '0;
            end else begin
               r_crc  <= w_crc_next;
               r_bcnt <= sat_add(r_bcnt, w_n);
            end
         end
         if (w_ld && w_fin) begin
            r_fcs_hi <= w_ext[95:64];
            r_fcs_n  <= 3'(w_n - 4'd4);
         end
         if (r_tvalid && m_axis_tready && r_tlast)
            r_frame_count <= r_frame_count + 32'd1;
         if (w_acc && w_err)
            r_err <= 1'b1;
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tkeep  = r_tkeep;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign frame_count   = r_frame_count;
   assign err_tkeep     = r_err;

endmodule

// File: tb/tb_eth_fcs_inserter.sv
// Directed bench for eth_fcs_inserter; expectations follow ETH_FCS_MIN_PAD_EN when it is defined.
module tb_eth_fcs_inserter;

   localparam int MINB = 60;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [63:0] s_tdata = '0;
   logic [7:0]  s_tkeep = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic        m_tlast;
   logic [31:0] frame_count;
   logic        err_tkeep;

   int          n_asrt = 0;
   int          n_fail = 0;
   logic [63:0] q_data[$];
   logic [7:0]  q_keep[$];
   logic        q_last[$];
   int          n_last = 0;
   logic        stall = 1'b0;
   logic        first_vld = 1'b0;
   byte unsigned fb[$];

   always #5 clk = ~clk;

   eth_fcs_inserter dut (
      .clk           (clk),
      .rstn          (rstn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .frame_count   (frame_count),
      .err_tkeep     (err_tkeep)
   );

   // Output beats are captured mid-cycle; the transfer completes at the following rising edge.
   always @(negedge clk) begin
      if (m_tvalid && m_tready) begin
         q_data.push_back(m_tdata);
         q_keep.push_back(m_tkeep);
         q_last.push_back(m_tlast);
         if (m_tlast) n_last++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (stall) m_tready = ~m_tready;
      #1;
   endtask

   function automatic logic [31:0] crc32(input byte unsigned b[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (b[i]) begin
         c = c ^ {24'h0, b[i]};
         repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   // Drives fb as a frame; lanes past the end of the frame carry filler 0xA5.
   task automatic send(input logic [7:0] kmid, input logic [7:0] klast, input int maxb);
      int nb;
      nb = (fb.size() + 7) / 8;
      for (int b = 0; b < nb && b < maxb; b++) begin
         int   g;
         logic acc;
         for (int i = 0; i < 8; i++)
            s_tdata[8*i +: 8] = (8*b + i < fb.size()) ? fb[8*b + i] : 8'hA5;
         s_tkeep  = (b == nb - 1) ? klast : kmid;
         s_tlast  = (b == nb - 1);
         s_tvalid = 1'b1;
         g = 0;
         do begin
            acc = s_tready;
            tick();
            g++;
         end while (!acc && g < 100);
         if (!acc) chk("in_timeout", 64'(acc), 64'd1);
         if (b == 0) first_vld = m_tvalid;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic expect_frame(input string tag, input int base, input int tgt);
      byte unsigned w[$];
      logic [31:0]  f;
      int           nexp;
      int           g;
      w = fb;
`ifdef ETH_FCS_MIN_PAD_EN
      while (w.size() < MINB) w.push_back(8'h00);
`endif
      f = crc32(w);
      for (int k = 0; k < 4; k++) w.push_back(f[8*k +: 8]);
      g = 0;
      while (n_last < tgt && g < 300) begin
         tick();
         g++;
      end
      chk({tag, "_done"}, 64'(n_last >= tgt), 64'd1);
      nexp = (w.size() + 7) / 8;
      chk({tag, "_beats"}, 64'(q_data.size() - base), 64'(nexp));
      for (int b = 0; b < nexp && base + b < q_data.size(); b++) begin
         logic [63:0] ed;
         logic [7:0]  ek;
         ed = '0;
         ek = '0;
         for (int i = 0; i < 8; i++) begin
            if (8*b + i < w.size()) begin
               ed[8*i +: 8] = w[8*b + i];
               ek[i]        = 1'b1;
            end
         end
         chk($sformatf("%s_data%0d", tag, b), q_data[base + b], ed);
         chk($sformatf("%s_keep%0d", tag, b), 64'(q_keep[base + b]), 64'(ek));
         chk($sformatf("%s_last%0d", tag, b), 64'(q_last[base + b]), 64'(b == nexp - 1));
      end
   endtask

   initial begin
      int base;
      int tgt;
      int fc0;

      // Reset state
      tick();
      tick();
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_m_tdata", m_tdata, 64'd0);
      chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
      chk("rst_m_tlast", 64'(m_tlast), 64'd0);
      chk("rst_frame_count", 64'(frame_count), 64'd0);
      chk("rst_err_tkeep", 64'(err_tkeep), 64'd0);
      rstn = 1'b1;
      tick();

      // "123456789": CRC check value 0xCBF43926
      fb.delete();
      for (int i = 0; i < 9; i++) fb.push_back(8'(8'h31 + i));
      base = q_data.size();
      tgt  = n_last + 1;
      send(8'hFF, 8'h01, 100);
      chk("f9_latency", 64'(first_vld), 64'd1);
      expect_frame("f9", base, tgt);
`ifndef ETH_FCS_MIN_PAD_EN
      if (q_data.size() >= base + 2) begin
         chk("f9_beat1", q_data[base], 64'h3837363534333231);
         chk("f9_beat2", q_data[base + 1], 64'h000000CBF4392639);
         chk("f9_keep2", 64'(q_keep[base + 1]), 64'h1F);
      end
`endif
      chk("f9_frame_count", 64'(frame_count), 64'd1);
      chk("f9_err", 64'(err_tkeep), 64'd0);

      // 14-byte frame: padded to 60 when padding is built, else 18 bytes on the wire
      fb.delete();
      for (int i = 0; i < 14; i++) fb.push_back(8'(i * 3 + 1));
      base = q_data.size();
      tgt  = n_last + 1;
      send(8'hFF, 8'h3F, 100);
      expect_frame("f14", base, tgt);

      // 68 bytes: FCS fits in the last beat
      fb.delete();
      for (int i = 0; i < 68; i++) fb.push_back(8'(i * 5 + 7));
      base = q_data.size();
      tgt  = n_last + 1;
      send(8'hFF, 8'h0F, 100);
      expect_frame("f68", base, tgt);
      chk("f68_nbeats", 64'(q_data.size() - base), 64'd9);

      // 62 bytes: FCS split across two beats
      fb.delete();
      for (int i = 0; i < 62; i++) fb.push_back(8'(255 - i));
      base = q_data.size();
      tgt  = n_last + 1;
      send(8'hFF, 8'h3F, 100);
      expect_frame("f62", base, tgt);
      chk("f62_nbeats", 64'(q_data.size() - base), 64'd9);
      if (q_keep.size() >= base + 9) begin
         chk("f62_keep8", 64'(q_keep[base + 7]), 64'hFF);
         chk("f62_keep9", 64'(q_keep[base + 8]), 64'h03);
      end

      // 64 bytes, free-running and then with m_axis_tready toggling 1,0,1,0
      fb.delete();
      for (int i = 0; i < 64; i++) fb.push_back(8'(i * 11 + 3));
      base = q_data.size();
      tgt  = n_last + 1;
      send(8'hFF, 8'hFF, 100);
      expect_frame("f64", base, tgt);
      fc0   = int'(frame_count);
      base  = q_data.size();
      tgt   = n_last + 1;
      stall = 1'b1;
      send(8'hFF, 8'hFF, 100);
      expect_frame("f64s", base, tgt);
      stall    = 1'b0;
      m_tready = 1'b1;
      chk("f64s_frame_count", 64'(frame_count), 64'(fc0 + 1));

      // tkeep violations: 0x7F on a middle beat, 0x05 on the last beat (treated as 1 byte)
      fb.delete();
      for (int i = 0; i < 9; i++) fb.push_back(8'(8'h41 + i));
      base = q_data.size();
      tgt  = n_last + 1;
      send(8'h7F, 8'h05, 100);
      expect_frame("fbad", base, tgt);
      chk("fbad_err", 64'(err_tkeep), 64'd1);

      // Reset during beat 4 of a 10-beat frame
      fb.delete();
      for (int i = 0; i < 80; i++) fb.push_back(8'(i + 100));
      send(8'hFF, 8'hFF, 3);
      s_tdata  = 64'h0123456789ABCDEF;
      s_tkeep  = 8'hFF;
      s_tvalid = 1'b1;
      rstn     = 1'b0;
      tick();
      chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
      s_tvalid = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      chk("mid_rst_err", 64'(err_tkeep), 64'd0);
      chk("mid_rst_frame_count", 64'(frame_count), 64'd0);
      fb.delete();
      for (int i = 0; i < 20; i++) fb.push_back(8'(i * 7 + 9));
      base = q_data.size();
      tgt  = n_last + 1;
      send(8'hFF, 8'h0F, 100);
      expect_frame("f20", base, tgt);
      chk("f20_frame_count", 64'(frame_count), 64'd1);
      chk("f20_err", 64'(err_tkeep), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
